// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// IF looks up the fetch PC combinationally; EX trains the table one update per
// cycle. The table lives in flops rather than RAM because every entry must clear
// on reset and on inval_all, and lookup has zero latency.
// Optional feature: define BTB_STATS_EN to add lookup/hit/mispredict counters.
module branch_target_buffer #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [1:0]        pred_counter,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              inval_all
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]       stat_lookups,
  output logic [15:0]       stat_hits,
  output logic [15:0]       stat_mispred
`endif
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  // Flattened view of the per-entry state, used by the lookup mux.
  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_arr    [ENTRIES];
  logic [ADDR_W-1:0]  target_arr [ENTRIES];
  logic [1:0]         cnt_arr    [ENTRIES];

  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic [INDEX_W-1:0] upd_index;
  logic [TAG_W-1:0]   upd_tag;

  assign lk_index  = lookup_pc[INDEX_W+1:2];
  assign lk_tag    = lookup_pc[ADDR_W-1:INDEX_W+2];
  assign upd_index = upd_pc[INDEX_W+1:2];
  assign upd_tag   = upd_pc[ADDR_W-1:INDEX_W+2];

  // Byte-offset bits of both PCs are ignored by design.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [ADDR_W-1:0] target_reg;
      logic [1:0]        cnt_reg;
      logic              sel;
      logic              tag_match;

      // upd_valid gates everything so unknown upd_* fields cannot disturb state.
      assign sel       = upd_valid && (upd_index == INDEX_W'(gi));
      assign tag_match = valid_reg && (tag_reg == upd_tag);

      // Entry training: counters saturate, taken misses allocate, NT misses are ignored.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          cnt_reg    <= 2'b01;
        end else if (inval_all) begin
          // Invalidate wins over a coincident update; cnt/target are kept.
          valid_reg <= 1'b0;
        end else if (sel) begin
          if (tag_match) begin
            if (upd_taken) begin
              cnt_reg    <= (cnt_reg == 2'b11) ? 2'b11 : cnt_reg + 2'b01;
              target_reg <= upd_target;
            end else begin
              cnt_reg <= (cnt_reg == 2'b00) ? 2'b00 : cnt_reg - 2'b01;
            end
          end else if (upd_taken) begin
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= upd_target;
            cnt_reg    <= 2'b10;
          end
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign cnt_arr[gi]    = cnt_reg;
    end
  endgenerate

  // Zero-latency prediction from the stored table; no bypass from the update port.
  always_comb begin
    pred_hit     = valid_vec[lk_index] && (tag_arr[lk_index] == lk_tag);
    pred_taken   = pred_hit && cnt_arr[lk_index][1];
    pred_counter = pred_hit ? cnt_arr[lk_index] : 2'b01;
    pred_target  = pred_taken ? target_arr[lk_index] : lookup_pc + ADDR_W'(4);
  end

`ifdef BTB_STATS_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_mispred <= '0;
    end else begin
      if (stat_lookups != 16'hFFFF) begin
        stat_lookups <= stat_lookups + 16'd1;
      end
      if (pred_hit && (stat_hits != 16'hFFFF)) begin
        stat_hits <= stat_hits + 16'd1;
      end
      if (upd_valid && upd_mispredict && (stat_mispred != 16'hFFFF)) begin
        stat_mispred <= stat_mispred + 16'd1;
      end
    end
  end
`else
  // The mispredict flag only feeds the statistics.
  logic unused_mispredict;
  assign unused_mispredict = upd_mispredict;
`endif

endmodule
